// File: rtl/stream_check_monitor.sv
// stream_check_monitor: in-hardware scoreboard. Expected words are queued in a
// FIFO and each inspected word is compared against the oldest queued word.
// Keeps saturating test/error totals, per-group summaries and a registered
// record of the first and latest mismatches.
module stream_check_monitor #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     exp_data,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [W-1:0]     ins_data,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic             group_begin,
    input  logic             group_end,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] group_tests,
    output logic [CNT_W-1:0] group_errors,
    output logic             group_done,
    output logic             group_pass,
    output logic             in_group,
    output logic             fail_pulse,
    output logic [W-1:0]     fail_exp,
    output logic [W-1:0]     fail_ins,
    output logic [CNT_W-1:0] fail_index,
    output logic [CNT_W-1:0] first_fail_index,
    output logic             all_ok
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_OPEN} grp_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [W-1:0]     mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop, mismatch;
    logic [W-1:0]     head;
    logic [CNT_W-1:0] test_next, error_next;
    logic [CNT_W-1:0] snap_t, snap_e;
    grp_state_t       state_q, state_d;
    logic             snap_load, grp_close;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = (wr_ptr == rd_ptr);
    assign exp_ready = !full;
    assign ins_ready = !empty;
    assign push      = exp_valid && !full;
    assign pop       = ins_valid && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign mismatch  = pop && (ins_data != head);

    // Post-update totals; group snapshots and closes see this cycle's compare.
    assign test_next  = pop      ? sat_inc(test_count)  : test_count;
    assign error_next = mismatch ? sat_inc(error_count) : error_count;

    assign in_group = (state_q == ST_OPEN);
    assign all_ok   = (error_count == '0);

    // FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= exp_data;
    end

    // FIFO pointers and running totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            test_count  <= '0;
            error_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            test_count  <= test_next;
            error_count <= error_next;
        end
    end

    // Registered mismatch record, visible the cycle after the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_pulse       <= 1'b0;
            fail_exp         <= '0;
            fail_ins         <= '0;
            fail_index       <= '0;
            first_fail_index <= '0;
        end else begin
            fail_pulse <= mismatch;
            if (mismatch) begin
                fail_exp   <= head;
                fail_ins   <= ins_data;
                fail_index <= test_next;
                if (first_fail_index == '0) first_fail_index <= test_next;
            end
        end
    end

    // Group FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Group FSM next state: a begin while open restarts the group; begin with
    // end while open closes the old group and opens a new one.
    always_comb begin
        state_d   = state_q;
        snap_load = 1'b0;
        grp_close = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (group_begin) begin
                    state_d   = ST_OPEN;
                    snap_load = 1'b1;
                end
            end
            ST_OPEN: begin
                if (group_end) begin
                    grp_close = 1'b1;
                    if (group_begin) snap_load = 1'b1;
                    else             state_d   = ST_IDLE;
                end else if (group_begin) begin
                    snap_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Group snapshots and closed-group summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_t       <= '0;
            snap_e       <= '0;
            group_tests  <= '0;
            group_errors <= '0;
            group_pass   <= 1'b0;
            group_done   <= 1'b0;
        end else begin
            group_done <= grp_close;
            if (grp_close) begin
                group_tests  <= test_next - snap_t;
                group_errors <= error_next - snap_e;
                group_pass   <= (error_next == snap_e);
            end
            if (snap_load) begin
                snap_t <= test_next;
                snap_e <= error_next;
            end
        end
    end

endmodule

// File: tb/tb_stream_check_monitor.sv
// Self-checking bench: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a queue-based reference scoreboard.
module tb_stream_check_monitor;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     exp_data, ins_data;
    logic             exp_valid, ins_valid, exp_ready, ins_ready;
    logic             group_begin, group_end;
    logic [CNT_W-1:0] test_count, error_count, group_tests, group_errors;
    logic             group_done, group_pass, in_group, fail_pulse, all_ok;
    logic [W-1:0]     fail_exp, fail_ins;
    logic [CNT_W-1:0] fail_index, first_fail_index;

    stream_check_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .exp_data(exp_data), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .ins_data(ins_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .group_begin(group_begin), .group_end(group_end),
        .test_count(test_count), .error_count(error_count),
        .group_tests(group_tests), .group_errors(group_errors),
        .group_done(group_done), .group_pass(group_pass), .in_group(in_group),
        .fail_pulse(fail_pulse), .fail_exp(fail_exp), .fail_ins(fail_ins),
        .fail_index(fail_index), .first_fail_index(first_fail_index),
        .all_ok(all_ok)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference scoreboard state.
    int q[$];
    int m_tc, m_ec, m_gt, m_ge, m_st, m_se, m_fe, m_fi, m_fidx, m_ffi;
    bit m_gp, m_gd, m_ing, m_fp;

    function automatic int sat1(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tc = 0; m_ec = 0; m_gt = 0; m_ge = 0; m_st = 0; m_se = 0;
        m_fe = 0; m_fi = 0; m_fidx = 0; m_ffi = 0;
        m_gp = 0; m_gd = 0; m_ing = 0; m_fp = 0;
    endtask

    task automatic check_all();
        check_val("exp_ready", exp_ready, q.size() < DEPTH);
        check_val("ins_ready", ins_ready, q.size() > 0);
        check_val("test_count", test_count, m_tc);
        check_val("error_count", error_count, m_ec);
        check_val("all_ok", all_ok, m_ec == 0);
        check_val("group_tests", group_tests, m_gt);
        check_val("group_errors", group_errors, m_ge);
        check_val("group_pass", group_pass, m_gp);
        check_val("group_done", group_done, m_gd);
        check_val("in_group", in_group, m_ing);
        check_val("fail_pulse", fail_pulse, m_fp);
        check_val("fail_exp", fail_exp, m_fe);
        check_val("fail_ins", fail_ins, m_fi);
        check_val("fail_index", fail_index, m_fidx);
        check_val("first_fail_index", first_fail_index, m_ffi);
    endtask

    // One clock: inputs are already driven; advance and compare with the model.
    task automatic step();
        bit do_push, do_pop, mism;
        int tcn, ecn, head;
        check_val("pre_exp_ready", exp_ready, q.size() < DEPTH);
        check_val("pre_ins_ready", ins_ready, q.size() > 0);
        do_push = exp_valid && (q.size() < DEPTH);
        do_pop  = ins_valid && (q.size() > 0);
        head    = (q.size() > 0) ? q[0] : 0;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            mism = do_pop && (int'(ins_data) != head);
            tcn  = do_pop ? sat1(m_tc) : m_tc;
            ecn  = mism ? sat1(m_ec) : m_ec;
            m_fp = mism;
            if (mism) begin
                m_fe = head; m_fi = ins_data; m_fidx = tcn;
                if (m_ffi == 0) m_ffi = tcn;
            end
            m_gd = 0;
            if (!m_ing) begin
                if (group_begin) begin m_ing = 1; m_st = tcn; m_se = ecn; end
            end else if (group_end) begin
                m_gt = tcn - m_st; m_ge = ecn - m_se; m_gp = (m_ge == 0); m_gd = 1;
                if (group_begin) begin m_st = tcn; m_se = ecn; end
                else m_ing = 0;
            end else if (group_begin) begin
                m_st = tcn; m_se = ecn;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(int'(exp_data));
            m_tc = tcn; m_ec = ecn;
        end
        check_all();
    endtask

    task automatic drive(input bit r, input bit ev, input int ed, input bit iv, input int id,
                         input bit gb, input bit ge);
        rst = r; exp_valid = ev; exp_data = ed[W-1:0]; ins_valid = iv; ins_data = id[W-1:0];
        group_begin = gb; group_end = ge;
        step();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        rst = 1; exp_valid = 0; exp_data = 0; ins_valid = 0; ins_data = 0;
        group_begin = 0; group_end = 0;
        @(posedge clk); #1;
        do_reset();
        check_val("rst_test_count", test_count, 0);
        check_val("rst_all_ok", all_ok, 1);
        check_val("rst_exp_ready", exp_ready, 1);
        check_val("rst_ins_ready", ins_ready, 0);
        check_val("rst_first_fail", first_fail_index, 0);

        // Matching stream.
        drive(0, 1, 'h11, 0, 0, 0, 0);
        drive(0, 1, 'h22, 0, 0, 0, 0);
        drive(0, 1, 'h33, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 'h11, 0, 0);
        drive(0, 0, 0, 1, 'h22, 0, 0);
        drive(0, 0, 0, 1, 'h33, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_val("match_tc", test_count, 3);
        check_val("match_ec", error_count, 0);
        check_val("match_all_ok", all_ok, 1);

        // Single mismatch after reset.
        do_reset();
        drive(0, 1, 'hA5, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 'h5A, 0, 0);
        check_val("mm_pulse", fail_pulse, 1);
        check_val("mm_fail_exp", fail_exp, 'hA5);
        check_val("mm_fail_ins", fail_ins, 'h5A);
        check_val("mm_fail_index", fail_index, 1);
        check_val("mm_first_fail", first_fail_index, 1);
        check_val("mm_all_ok", all_ok, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_val("mm_pulse_off", fail_pulse, 0);

        // Fill to full, hold off, pop once, then drain through the wrap.
        do_reset();
        for (int i = 0; i < 16; i++) drive(0, 1, 'h40 + i, 0, 0, 0, 0);
        check_val("full_exp_ready", exp_ready, 0);
        drive(0, 1, 'hEE, 0, 0, 0, 0);
        drive(0, 1, 'hEE, 1, 'h40, 0, 0);
        check_val("full_reopen", exp_ready, 1);
        drive(0, 1, 'hEE, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) drive(0, 0, 0, 1, 'h40 + i, 0, 0);
        drive(0, 0, 0, 1, 'hEE, 0, 0);
        check_val("wrap_ec", error_count, 0);

        // Compare attempt while empty, then a push.
        drive(0, 0, 0, 1, 'h00, 0, 0);
        check_val("empty_tc", test_count, 17);
        drive(0, 1, 'h77, 0, 0, 0, 0);
        check_val("push_ins_ready", ins_ready, 1);

        // Group of 5 compares, one mismatch, end coincident with the 5th.
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, 'h10 + i, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 'h10, 0, 0);
        drive(0, 0, 0, 1, 'hFF, 0, 0);
        drive(0, 0, 0, 1, 'h12, 0, 0);
        drive(0, 0, 0, 1, 'h13, 0, 0);
        drive(0, 0, 0, 1, 'h14, 0, 1);
        check_val("grp_done", group_done, 1);
        check_val("grp_tests", group_tests, 5);
        check_val("grp_errors", group_errors, 1);
        check_val("grp_pass", group_pass, 0);
        check_val("grp_closed", in_group, 0);

        // Begin+end together while open, then reset mid-group.
        drive(0, 1, 'h55, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 'h55, 1, 1);
        check_val("be_done", group_done, 1);
        check_val("be_tests", group_tests, 1);
        check_val("be_in_group", in_group, 1);
        drive(0, 1, 'h66, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_val("rst_mid_in_group", in_group, 0);
        check_val("rst_mid_tc", test_count, 0);
        check_val("rst_mid_ins_ready", ins_ready, 0);

        // Randomized traffic, long enough to drive the counters into saturation.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int id;
            id = ((q.size() > 0) && ($urandom_range(9) < 7)) ? q[0] : int'($urandom_range(255));
            drive($urandom_range(199) == 0, $urandom_range(1), int'($urandom_range(255)),
                  $urandom_range(1), id, $urandom_range(9) == 0, $urandom_range(9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_check_monitor.md
Name: stream_check_monitor

Overview:
- Synthesizable, in-hardware counterpart of the testbench check tasks.
- An expected-value producer pushes reference words into an internal FIFO. The DUT output side presents inspected words, and each one is compared against the oldest expected word.
- Tracks a running test count and error count, group begin/end summaries, and a registered record of the first and latest failures.
- Sits beside the transmitter datapath on the board or in a bench, and exposes its results to LEDs, the display or a UART status path.

Parameters:
- W, 8, data width of expected and inspected words.
- DEPTH, 16, expected-FIFO depth; must be a power of 2, at least 2.
- CNT_W, 16, width of all test and error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- exp_data  in  W  expected word.
- exp_valid  in  1  expected word offered.
- exp_ready  out  1  FIFO can accept a word; equals !full.
- ins_data  in  W  inspected word from the DUT.
- ins_valid  in  1  inspected word offered.
- ins_ready  out  1  a comparison can occur; equals !empty.
- group_begin  in  1  one-cycle strobe that opens a group.
- group_end  in  1  one-cycle strobe that closes a group.
- test_count  out  CNT_W  total comparisons performed.
- error_count  out  CNT_W  total mismatches.
- group_tests  out  CNT_W  comparisons in the last closed group.
- group_errors  out  CNT_W  mismatches in the last closed group.
- group_done  out  1  one-cycle pulse when the group results are updated.
- group_pass  out  1  last closed group had zero errors.
- in_group  out  1  a group is currently open.
- fail_pulse  out  1  one-cycle pulse for each mismatch.
- fail_exp  out  W  expected word of the latest mismatch.
- fail_ins  out  W  inspected word of the latest mismatch.
- fail_index  out  CNT_W  test number (1-based) of the latest mismatch.
- first_fail_index  out  CNT_W  test number of the first mismatch since reset; 0 if none.
- all_ok  out  1  error_count == 0.

Behaviour:
- Reset state:
  - All counters, indices, fail_exp and fail_ins are 0.
  - fail_pulse, group_done, group_pass and in_group are 0.
  - all_ok is 1.
  - FIFO is empty, so exp_ready=1 and ins_ready=0.
  - Reset mid-operation discards FIFO contents and any open group.
- Push: occurs when exp_valid && exp_ready at a clk edge.
  - The word becomes poppable the next cycle; there is no fall-through.
  - When full, exp_ready=0 and the word is held off upstream.
- Compare: occurs when ins_valid && ins_ready at a clk edge.
  - Pops the FIFO head.
  - test_count increments.
  - If ins_data != head, error_count increments.
- Push and pop in the same cycle:
  - Legal whenever ready allows.
  - Occupancy is unchanged.
  - A full FIFO cannot push that cycle, since exp_ready is 0.
- Mismatch reporting is registered, with 1-cycle latency:
  - fail_pulse=1 for one cycle.
  - fail_exp and fail_ins hold the compared words.
  - fail_index holds the new test_count.
  - first_fail_index is written only while it is 0.
- Counters saturate at 2^CNT_W-1 and never wrap. Index capture uses the saturated value.
- Group FSM, with states IDLE and OPEN (in_group = state==OPEN):
  - IDLE + group_begin goes to OPEN. It snapshots test_count and error_count, post-update if a compare happens that same cycle.
  - OPEN + group_end goes to IDLE.
    - group_tests = test_count_next - snapshot_t.
    - group_errors = error_count_next - snapshot_e.
    - A compare in the same cycle counts in the closing group.
    - group_done pulses the next cycle.
    - group_pass = (group_errors == 0).
  - OPEN + group_begin (without end) re-snapshots and stays OPEN. No group_done is issued.
  - OPEN + group_begin + group_end together: the current group closes with group_done, then a new group opens immediately and the FSM stays OPEN.
  - IDLE + group_end is ignored.
  - IDLE + group_begin + group_end together is treated as begin only.
- group_tests, group_errors and group_pass hold their values until the next group_done.
- Pointers are log2(DEPTH) bits plus a wrap bit.
  - full = pointer bits equal and wrap bits differ.
  - empty = pointers fully equal.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 and present matching inspected words:
  - test_count=3, error_count=0, all_ok=1.
  - fail_pulse never asserts.
- Push 0xA5 and present 0x5A:
  - fail_pulse pulses one cycle after the compare.
  - fail_exp=0xA5, fail_ins=0x5A, fail_index=1, first_fail_index=1.
  - error_count=1, all_ok=0.
- Push 16 words with ins_valid=0:
  - exp_ready falls after the 16th push, and a 17th offer is held off.
  - One pop re-raises exp_ready. Data order is preserved through the wrap.
- Compare with the FIFO empty:
  - ins_ready=0 and no count change.
  - A push makes ins_ready=1 one cycle later.
- Group test:
  - group_begin, then 4 compares with 1 mismatch, then group_end coincident with a 5th (matching) compare.
  - group_done pulses, group_tests=5, group_errors=1, group_pass=0.
- Simultaneous begin and end while OPEN:
  - The prior group is reported and in_group stays 1.
  - Asserting rst mid-group clears in_group, the counters and the FIFO in one cycle.
